axis_burst_reader: RTL and testbench

- Downstream stage of the synchronous AXI4-Stream FIFO.
- Watches the FIFO's exact read-side word count and releases data only in whole bursts of cfg_length words, with m_axis_tlast marking the last word of each burst.
- A programmable timeout flushes a partial burst when the FIFO holds data but not enough for a full burst.
- Feeds packet-oriented consumers such as DMA writers.

---
 rtl/axis_burst_pkg.sv | 12 +
 rtl/axis_burst_reader.sv | 108 ++++++++++
 tb/tb_axis_burst_reader.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_burst_pkg.sv
// Shared types for the AXI4-Stream burst reader.
// Holds the FSM encoding and the burst length width.
package axis_burst_pkg;

    localparam int LENGTH_WIDTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/axis_burst_reader.sv
// Releases FIFO data in whole bursts of cfg_length words with tlast,
// flushing a partial burst after a programmable idle timeout.
module axis_burst_reader
    import axis_burst_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_enable,
    input  logic [LENGTH_WIDTH-1:0]     cfg_length,
    input  logic [CNTR_WIDTH-1:0]       cfg_timeout,
    input  logic [CNTR_WIDTH-1:0]       fifo_count,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [CNTR_WIDTH-1:0]       sts_bursts,
    output logic [CNTR_WIDTH-1:0]       sts_partial,
    output logic                        busy
);

    state_t                  state;
    logic [LENGTH_WIDTH-1:0] remaining;
    logic [CNTR_WIDTH-1:0]   timer;
    logic                    partial;

    logic [CNTR_WIDTH-1:0]   length_ext;
    logic [CNTR_WIDTH-1:0]   timer_inc;
    logic                    full_go;
    logic                    timer_run;
    logic                    flush_go;
    logic                    beat;
    logic                    last;

    assign length_ext = CNTR_WIDTH'(cfg_length);

    // The timer saturates so a long wait can never wrap and miss the flush.
    assign timer_inc = (&timer) ? timer : timer + CNTR_WIDTH'(1);

    assign full_go = cfg_enable && (cfg_length != '0)
                     && (fifo_count >= length_ext);

    assign timer_run = cfg_enable && (cfg_timeout != '0)
                       && (fifo_count != '0)
                       && (fifo_count < length_ext);

    assign flush_go = timer_run && (timer_inc >= cfg_timeout);

    assign busy          = (state == BURST);
    assign beat          = busy && s_axis_tvalid && m_axis_tready;
    assign last          = busy && (remaining == '0);
    assign m_axis_tlast  = last;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = busy && s_axis_tvalid;
    assign s_axis_tready = busy && m_axis_tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= IDLE;
            remaining   <= '0;
            timer       <= '0;
            partial     <= 1'b0;
            sts_bursts  <= '0;
            sts_partial <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (full_go) begin
                        state     <= BURST;
                        remaining <= cfg_length - LENGTH_WIDTH'(1);
                        partial   <= 1'b0;
                        timer     <= '0;
                    end else if (flush_go) begin
                        state     <= BURST;
                        remaining <= fifo_count[LENGTH_WIDTH-1:0]
                                     - LENGTH_WIDTH'(1);
                        partial   <= 1'b1;
                        timer     <= '0;
                    end else if (timer_run) begin
                        timer <= timer_inc;
                    end else begin
                        timer <= '0;
                    end
                end
                BURST: begin
                    if (beat) begin
                        if (last) begin
                            state      <= IDLE;
                            sts_bursts <= sts_bursts + CNTR_WIDTH'(1);
                            if (partial) begin
                                sts_partial <= sts_partial + CNTR_WIDTH'(1);
                            end
                        end else begin
                            remaining <= remaining - LENGTH_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_burst_reader.sv
// Self-checking bench: a queue-based FIFO model feeds the reader and a
// burst-level reference model predicts every output beat and counter.
module tb_axis_burst_reader;

    localparam int DW = 32;
    localparam int CW = 32;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cfg_enable = 1'b0;
    logic [15:0]   cfg_length = '0;
    logic [CW-1:0] cfg_timeout = '0;
    logic [CW-1:0] fifo_count = '0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [CW-1:0] sts_bursts;
    logic [CW-1:0] sts_partial;
    logic          busy;

    axis_burst_reader #(
        .AXIS_TDATA_WIDTH(DW),
        .CNTR_WIDTH(CW)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .cfg_enable(cfg_enable),
        .cfg_length(cfg_length),
        .cfg_timeout(cfg_timeout),
        .fifo_count(fifo_count),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .sts_bursts(sts_bursts),
        .sts_partial(sts_partial),
        .busy(busy)
    );

    always #5 aclk = ~aclk;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_d[$];
    bit            exp_l[$];
    int            exp_bursts;
    int            exp_partial;
    int            n_checks;
    int            n_fail;
    int            beats;
    int            cyc;
    int            rdy_mode;
    bit            gap_mode;
    bit            gap;
    bit            last_busy;
    bit            seen_busy;

    task automatic drive_fifo();
        s_axis_tvalid = (fq.size() != 0) && !gap;
        s_axis_tdata  = (fq.size() != 0) ? fq[0] : '0;
        fifo_count    = CW'(fq.size());
    endtask

    task automatic load_fifo(input int n, input bit ramp);
        fq.delete();
        for (int i = 0; i < n; i++) begin
            fq.push_back(ramp ? DW'(i) : DW'($urandom));
        end
    endtask

    // Burst-level prediction from the words present at start: whole
    // bursts of L, then the leftover as one partial when a timeout is set.
    task automatic model_bursts(input int L, input int T, input int n);
        int nf;
        int r;
        if (L == 0) return;
        nf = n / L;
        r  = n % L;
        for (int i = 0; i < nf * L; i++) begin
            exp_d.push_back(fq[i]);
            exp_l.push_back((i % L) == (L - 1));
        end
        exp_bursts += nf;
        if (r != 0 && T != 0) begin
            for (int i = 0; i < r; i++) begin
                exp_d.push_back(fq[nf * L + i]);
                exp_l.push_back(i == r - 1);
            end
            exp_bursts++;
            exp_partial++;
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        gap = 1'b0;
        m_axis_tready = 1'b1;
        drive_fifo();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_bursts = 0;
        exp_partial = 0;
        exp_d.delete();
        exp_l.delete();
        beats = 0;
        cyc = 0;
        seen_busy = 1'b0;
    endtask

    task automatic step();
        logic          hs;
        logic [DW-1:0] d;
        bit            l;
        @(negedge aclk);
        last_busy = busy;
        if (busy) seen_busy = 1'b1;
        if (m_axis_tvalid && m_axis_tready) begin
            beats++;
            n_checks++;
            if (exp_d.size() == 0) begin
                n_fail++;
                $display("FAIL extra_beat: got data %h tlast %b, required no beat",
                         m_axis_tdata, m_axis_tlast);
            end else begin
                d = exp_d.pop_front();
                l = exp_l.pop_front();
                if (m_axis_tdata !== d || m_axis_tlast !== l) begin
                    n_fail++;
                    $display("FAIL beat_%0d: got %h/%b, required %h/%b",
                             beats, m_axis_tdata, m_axis_tlast, d, l);
                end
            end
        end
        hs = s_axis_tvalid && s_axis_tready;
        @(posedge aclk);
        #1;
        if (hs) void'(fq.pop_front());
        cyc++;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = (cyc % 3 == 0);
            default: m_axis_tready = ($urandom_range(3) != 0);
        endcase
        gap = gap_mode ? ($urandom_range(3) == 0) : 1'b0;
        drive_fifo();
    endtask

    task automatic run_until(input int budget, input int settle);
        int c = 0;
        while (exp_d.size() != 0 && c < budget) begin
            step();
            c++;
        end
        n_checks++;
        if (exp_d.size() != 0) begin
            n_fail++;
            $display("FAIL burst_timeout: %0d beats outstanding, required 0",
                     exp_d.size());
        end
        repeat (settle) step();
    endtask

    task automatic check_counters(input string name, input int left);
        n_checks++;
        if (sts_bursts !== CW'(exp_bursts)) begin
            n_fail++;
            $display("FAIL %s_bursts: got %0d, required %0d",
                     name, sts_bursts, exp_bursts);
        end
        n_checks++;
        if (sts_partial !== CW'(exp_partial)) begin
            n_fail++;
            $display("FAIL %s_partial: got %0d, required %0d",
                     name, sts_partial, exp_partial);
        end
        n_checks++;
        if (fq.size() != left) begin
            n_fail++;
            $display("FAIL %s_left: got %0d, required %0d",
                     name, fq.size(), left);
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        rdy_mode = 0;
        gap_mode = 1'b0;
        fq.delete();
        cfg_enable = 1'b1;
        cfg_length = 16'd4;
        aresetn = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        d = DW'($urandom);
        s_axis_tdata = d;
        s_axis_tvalid = 1'b1;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: got tvalid %b tready %b, required 0 0",
                     m_axis_tvalid, s_axis_tready);
        end
        n_checks++;
        if (m_axis_tlast !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got tlast %b busy %b, required 0 0",
                     m_axis_tlast, busy);
        end
        n_checks++;
        if (sts_bursts !== '0 || sts_partial !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d %0d, required 0 0",
                     sts_bursts, sts_partial);
        end
        n_checks++;
        if (m_axis_tdata !== d) begin
            n_fail++;
            $display("FAIL passthru: got %h, required %h", m_axis_tdata, d);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_full_burst();
        rdy_mode = 0;
        gap_mode = 1'b0;
        load_fifo(10, 1'b1);
        cfg_enable = 1'b1;
        cfg_length = 16'd4;
        cfg_timeout = '0;
        do_reset();
        model_bursts(4, 0, 10);
        run_until(100, 20);
        check_counters("full", 2);
        n_checks++;
        if (fq.size() == 0 || fq[0] !== DW'(8)) begin
            n_fail++;
            $display("FAIL full_head: got %0d words, required word 8 at head",
                     fq.size());
        end
    endtask

    task automatic test_timeout();
        int idle = 0;
        rdy_mode = 0;
        gap_mode = 1'b0;
        load_fifo(3, 1'b0);
        cfg_enable = 1'b1;
        cfg_length = 16'd8;
        cfg_timeout = CW'(16);
        do_reset();
        model_bursts(8, 16, 3);
        for (int i = 0; i < 100; i++) begin
            step();
            if (last_busy) break;
            idle++;
        end
        n_checks++;
        if (idle != 16) begin
            n_fail++;
            $display("FAIL timeout_wait: got %0d idle cycles, required 16",
                     idle);
        end
        run_until(50, 40);
        check_counters("timeout", 0);
    endtask

    task automatic test_backpressure();
        int  c = 0;
        bit  started = 1'b0;
        bit  dropped = 1'b0;
        rdy_mode = 1;
        gap_mode = 1'b0;
        load_fifo(6, 1'b0);
        cfg_enable = 1'b1;
        cfg_length = 16'd4;
        cfg_timeout = '0;
        do_reset();
        model_bursts(4, 0, 6);
        while (exp_d.size() != 0 && c < 100) begin
            step();
            c++;
            if (last_busy) started = 1'b1;
            else if (started && exp_d.size() != 0) dropped = 1'b1;
        end
        n_checks++;
        if (!started || dropped) begin
            n_fail++;
            $display("FAIL bp_busy: got started %b dropped %b, required 1 0",
                     started, dropped);
        end
        run_until(10, 20);
        check_counters("bp", 2);
    endtask

    task automatic test_disable_mid();
        int c = 0;
        rdy_mode = 0;
        gap_mode = 1'b0;
        load_fifo(12, 1'b0);
        cfg_enable = 1'b1;
        cfg_length = 16'd6;
        cfg_timeout = '0;
        do_reset();
        model_bursts(6, 0, 6);
        while (beats < 2 && c < 100) begin
            step();
            c++;
        end
        cfg_enable = 1'b0;
        cfg_length = 16'd3;
        seen_busy = 1'b0;
        run_until(100, 0);
        seen_busy = 1'b0;
        repeat (30) step();
        check_counters("disable", 6);
        n_checks++;
        if (seen_busy) begin
            n_fail++;
            $display("FAIL disable_restart: got busy 1, required 0");
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        rdy_mode = 0;
        gap_mode = 1'b0;
        load_fifo(12, 1'b0);
        cfg_enable = 1'b1;
        cfg_length = 16'd4;
        cfg_timeout = '0;
        do_reset();
        model_bursts(4, 0, 8);
        while (beats < 6 && c < 100) begin
            step();
            c++;
        end
        n_checks++;
        if (sts_bursts !== CW'(1) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre: got bursts %0d busy %b, required 1 1",
                     sts_bursts, busy);
        end
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0
            || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_hs: got tvalid %b tready %b busy %b, required 0 0 0",
                     m_axis_tvalid, s_axis_tready, busy);
        end
        n_checks++;
        if (sts_bursts !== '0 || sts_partial !== '0) begin
            n_fail++;
            $display("FAIL rmid_cnt: got %0d %0d, required 0 0",
                     sts_bursts, sts_partial);
        end
        aresetn = 1'b1;
        exp_d.delete();
        exp_l.delete();
    endtask

    task automatic test_len0();
        rdy_mode = 0;
        gap_mode = 1'b0;
        load_fifo(100, 1'b0);
        cfg_enable = 1'b1;
        cfg_length = 16'd0;
        cfg_timeout = CW'(5);
        do_reset();
        model_bursts(0, 5, 100);
        run_until(10, 50);
        check_counters("len0", 100);
        n_checks++;
        if (seen_busy) begin
            n_fail++;
            $display("FAIL len0_busy: got busy 1, required 0");
        end
    endtask

    task automatic test_len1();
        rdy_mode = 0;
        gap_mode = 1'b0;
        load_fifo(5, 1'b0);
        cfg_enable = 1'b1;
        cfg_length = 16'd1;
        cfg_timeout = '0;
        do_reset();
        model_bursts(1, 0, 5);
        run_until(100, 10);
        check_counters("len1", 0);
    endtask

    task automatic test_random();
        int L;
        int n;
        int T;
        for (int it = 0; it < 10; it++) begin
            L = $urandom_range(1, 8);
            n = $urandom_range(0, 20);
            T = ($urandom_range(1) != 0) ? $urandom_range(1, 30) : 0;
            rdy_mode = 2;
            gap_mode = 1'b1;
            load_fifo(n, 1'b0);
            cfg_enable = 1'b1;
            cfg_length = 16'(L);
            cfg_timeout = CW'(T);
            do_reset();
            model_bursts(L, T, n);
            run_until(600, 60);
            check_counters("rand", (T != 0) ? 0 : n % L);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rdy_mode = 0;
        gap_mode = 1'b0;
        gap = 1'b0;
        test_reset();
        test_full_burst();
        test_timeout();
        test_backpressure();
        test_disable_mid();
        test_reset_mid();
        test_len0();
        test_len1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
